// File: rtl/regfile_source.sv
// Register-source (rename) table: per architectural register, the ROB entry that
// will produce its next value and whether that write is still pending.
module regfile_source #(
    parameter int AREGS    = 128,
    parameter int RENTRIES = 16,
    parameter int QSLOTS   = 4,
    localparam int RBITS   = $clog2(RENTRIES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [QSLOTS-1:0]         slotvd,
    input  logic [QSLOTS-1:0]         queuedOn,
    input  logic [QSLOTS-1:0]         slot_rfw,
    input  logic [7*QSLOTS-1:0]       Rd,
    input  logic [RBITS*QSLOTS-1:0]   slot_id,
    input  logic [7*QSLOTS-1:0]       Rs1,
    input  logic [7*QSLOTS-1:0]       Rs2,
    input  logic                      commit0_v,
    input  logic [RBITS-1:0]          commit0_id,
    input  logic [6:0]                commit0_tgt,
    input  logic                      commit1_v,
    input  logic [RBITS-1:0]          commit1_id,
    input  logic [6:0]                commit1_tgt,
    input  logic                      commit2_v,
    input  logic [RBITS-1:0]          commit2_id,
    input  logic [6:0]                commit2_tgt,
    input  logic                      commit3_v,
    input  logic [RBITS-1:0]          commit3_id,
    input  logic [6:0]                commit3_tgt,
    input  logic                      branchmiss,
    input  logic [RENTRIES-1:0]       squash_mask,
    output logic [(RBITS+1)*AREGS-1:0] rf_source,
    output logic [RBITS*QSLOTS-1:0]   src1_tag,
    output logic [RBITS*QSLOTS-1:0]   src2_tag,
    output logic [QSLOTS-1:0]         src1_pend,
    output logic [QSLOTS-1:0]         src2_pend
);

    localparam int NCOMMIT = 4;

    logic [QSLOTS-1:0][6:0]        rd;
    logic [QSLOTS-1:0][6:0]        rs1;
    logic [QSLOTS-1:0][6:0]        rs2;
    logic [QSLOTS-1:0][RBITS-1:0]  id;
    logic [NCOMMIT-1:0]            cv;
    logic [NCOMMIT-1:0][RBITS-1:0] cid;
    logic [NCOMMIT-1:0][6:0]       ct;
    logic [QSLOTS-1:0]             wr;

    logic [AREGS-1:0]              pend_q;
    logic [AREGS-1:0]              pend_d;
    logic [AREGS-1:0][RBITS-1:0]   tag_q;
    logic [AREGS-1:0][RBITS-1:0]   tag_d;

    assign rd  = Rd;
    assign rs1 = Rs1;
    assign rs2 = Rs2;
    assign id  = slot_id;
    assign cv  = {commit3_v, commit2_v, commit1_v, commit0_v};
    assign cid = {commit3_id, commit2_id, commit1_id, commit0_id};
    assign ct  = {commit3_tgt, commit2_tgt, commit1_tgt, commit0_tgt};

    // A slot renames its destination only if it really enqueued and no squash is under way.
    always_comb begin
        for (int s = 0; s < QSLOTS; s++)
            wr[s] = slotvd[s] & queuedOn[s] & slot_rfw[s] & (rd[s] != 7'd0) & ~branchmiss;
    end

    // Clears are applied first, then writers; later assignments win, so an enqueue
    // beats any clear of the same register and the highest slot beats lower ones.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
        pend_d = pend_q;
        tag_d  = tag_q;
        for (int r = 0; r < AREGS; r++)
            if (branchmiss && pend_q[r] && squash_mask[tag_q[r]])
                pend_d[r] = 1'b0;
        for (int n = 0; n < NCOMMIT; n++)
            if (cv[n] && pend_q[ct[n]] && (tag_q[ct[n]] == cid[n]))
                pend_d[ct[n]] = 1'b0;
        for (int s = 0; s < QSLOTS; s++)
            if (wr[s]) begin
                pend_d[rd[s]] = 1'b1;
                tag_d[rd[s]]  = id[s];
            end
        pend_d[0] = 1'b0;
        tag_d[0]  = '0;
    end

    always_ff @(posedge clk) begin
        // NOTE: the table is flops rather than a RAM, so every entry is reset; state updates use non-blocking assignments.
        if (rst) begin
            pend_q <= '0;
            tag_q  <= '0;
        end else begin
            pend_q <= pend_d;
            tag_q  <= tag_d;
        end
    end

    for (genvar r = 0; r < AREGS; r++) begin : g_out
        assign rf_source[r*(RBITS+1) +: RBITS+1] = {pend_q[r], tag_q[r]};
    end

    // Nearest lower same-group writer first, else the table with commit read-through.
    function automatic logic [RBITS:0] lookup(input int s, input logic [6:0] rs);
        logic             pend;
        logic [RBITS-1:0] tag;
        pend = pend_q[rs];
        tag  = tag_q[rs];
        for (int n = 0; n < NCOMMIT; n++)
            if (cv[n] && (ct[n] == rs) && (cid[n] == tag_q[rs]))
                pend = 1'b0;
        for (int j = 0; j < QSLOTS; j++)
            if ((j < s) && wr[j] && (rd[j] == rs)) begin
                pend = 1'b1;
                tag  = id[j];
            end
        if (rs == 7'd0) begin
            pend = 1'b0;
            tag  = '0;
        end
        return {pend, tag};
    endfunction

    always_comb begin
        src1_tag  = '0;
        src2_tag  = '0;
        src1_pend = '0;
        src2_pend = '0;
        for (int s = 0; s < QSLOTS; s++) begin
            {src1_pend[s], src1_tag[s*RBITS +: RBITS]} = lookup(s, rs1[s]);
            {src2_pend[s], src2_tag[s*RBITS +: RBITS]} = lookup(s, rs2[s]);
        end
    end

endmodule

// File: tb/tb_regfile_source.sv
// Directed bench for regfile_source: expected values go into a scoreboard queue
// as each step is driven and are popped when the DUT output is sampled.
module tb_regfile_source;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  slotvd, queuedOn, slot_rfw;
    logic [27:0] Rd, Rs1, Rs2;
    logic [15:0] slot_id;
    logic        commit0_v, commit1_v, commit2_v, commit3_v;
    logic [3:0]  commit0_id, commit1_id, commit2_id, commit3_id;
    logic [6:0]  commit0_tgt, commit1_tgt, commit2_tgt, commit3_tgt;
    logic        branchmiss;
    logic [15:0] squash_mask;
    logic [639:0] rf_source;
    logic [15:0] src1_tag, src2_tag;
    logic [3:0]  src1_pend, src2_pend;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    regfile_source dut (
        .clk(clk), .rst(rst),
        .slotvd(slotvd), .queuedOn(queuedOn), .slot_rfw(slot_rfw),
        .Rd(Rd), .slot_id(slot_id), .Rs1(Rs1), .Rs2(Rs2),
        .commit0_v(commit0_v), .commit0_id(commit0_id), .commit0_tgt(commit0_tgt),
        .commit1_v(commit1_v), .commit1_id(commit1_id), .commit1_tgt(commit1_tgt),
        .commit2_v(commit2_v), .commit2_id(commit2_id), .commit2_tgt(commit2_tgt),
        .commit3_v(commit3_v), .commit3_id(commit3_id), .commit3_tgt(commit3_tgt),
        .branchmiss(branchmiss), .squash_mask(squash_mask),
        .rf_source(rf_source),
        .src1_tag(src1_tag), .src2_tag(src2_tag),
        .src1_pend(src1_pend), .src2_pend(src2_pend)
    );

    always #5 clk = ~clk;

    task automatic expect_v(input string name, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] observed);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h", observed);
        end else begin
            e = sb.pop_front();
            assert (observed === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.name, observed, e.val);
            end
        end
    endtask

    function automatic logic [31:0] entry(input int r);
        return 32'(rf_source[r*5 +: 5]);
    endfunction

    function automatic logic [31:0] t1(input int s);
        return 32'(src1_tag[s*4 +: 4]);
    endfunction

    function automatic logic [31:0] t2(input int s);
        return 32'(src2_tag[s*4 +: 4]);
    endfunction

    task automatic clear_inputs();
        slotvd = '0; queuedOn = '0; slot_rfw = '0;
        Rd = '0; Rs1 = '0; Rs2 = '0; slot_id = '0;
        commit0_v = 1'b0; commit0_id = '0; commit0_tgt = '0;
        commit1_v = 1'b0; commit1_id = '0; commit1_tgt = '0;
        commit2_v = 1'b0; commit2_id = '0; commit2_tgt = '0;
        commit3_v = 1'b0; commit3_id = '0; commit3_tgt = '0;
        branchmiss = 1'b0; squash_mask = '0;
    endtask

    task automatic set_wr(input int s, input logic [6:0] r, input logic [3:0] i);
        slotvd[s] = 1'b1; queuedOn[s] = 1'b1; slot_rfw[s] = 1'b1;
        Rd[s*7 +: 7] = r;
        slot_id[s*4 +: 4] = i;
    endtask

    task automatic set_rs(input int s, input logic [6:0] a, input logic [6:0] b);
        Rs1[s*7 +: 7] = a;
        Rs2[s*7 +: 7] = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with every slot enqueuing and a commit active.
        clear_inputs();
        rst = 1'b1;
        for (int s = 0; s < 4; s++) set_wr(s, 7'(10 + s), 4'(s + 1));
        commit0_v = 1'b1; commit0_id = 4'd1; commit0_tgt = 7'd10;
        tick();
        expect_v("rst_e10", 0);  check(entry(10));
        expect_v("rst_e13", 0);  check(entry(13));
        expect_v("rst_all", 0);  check(32'(|rf_source));
        rst = 1'b0;
        clear_inputs();
        for (int s = 0; s < 4; s++) set_rs(s, 7'(10 + s), 7'd5);
        #1;
        expect_v("rst_src1_pend", 0); check(32'(src1_pend));
        expect_v("rst_src2_pend", 0); check(32'(src2_pend));

        // Enqueue r5 <- id 3, then commit it.
        clear_inputs();
        set_wr(0, 7'd5, 4'd3);
        set_rs(2, 7'd5, 7'd0);
        #1;
        expect_v("enq_byp_tag", 3);  check(t1(2));
        expect_v("enq_byp_pend", 1); check(32'(src1_pend[2]));
        tick();
        expect_v("enq_e5", 32'h13); check(entry(5));
        clear_inputs();
        set_rs(1, 7'd5, 7'd0);
        #1;
        expect_v("tbl_pend", 1); check(32'(src1_pend[1]));
        commit0_v = 1'b1; commit0_id = 4'd3; commit0_tgt = 7'd5;
        #1;
        expect_v("rt_pend", 0); check(32'(src1_pend[1]));
        expect_v("rt_tag", 3);  check(t1(1));
        tick();
        expect_v("cmt_e5", 32'h03); check(entry(5));

        // Stale commit loses to a new writer.
        clear_inputs();
        set_wr(0, 7'd7, 4'd2);
        tick();
        expect_v("stale_pre_e7", 32'h12); check(entry(7));
        clear_inputs();
        set_wr(1, 7'd7, 4'd9);
        commit0_v = 1'b1; commit0_id = 4'd2; commit0_tgt = 7'd7;
        tick();
        expect_v("stale_e7", 32'h19); check(entry(7));

        // Four commits to r7: only the id-9 buses match, duplicates are harmless.
        clear_inputs();
        commit0_v = 1'b1; commit0_id = 4'd9; commit0_tgt = 7'd7;
        commit1_v = 1'b1; commit1_id = 4'd2; commit1_tgt = 7'd7;
        commit2_v = 1'b1; commit2_id = 4'd9; commit2_tgt = 7'd7;
        commit3_v = 1'b1; commit3_id = 4'd5; commit3_tgt = 7'd7;
        set_rs(0, 7'd7, 7'd7);
        #1;
        expect_v("dup_rt_pend1", 0); check(32'(src1_pend[0]));
        expect_v("dup_rt_pend2", 0); check(32'(src2_pend[0]));
        tick();
        expect_v("dup_e7", 32'h09); check(entry(7));

        // Intra-group bypass and highest-slot-wins.
        clear_inputs();
        set_wr(0, 7'd4, 4'd1);
        set_wr(2, 7'd4, 4'd6);
        set_rs(3, 7'd4, 7'd0);
        set_rs(1, 7'd0, 7'd4);
        set_rs(2, 7'd4, 7'd0);
        set_rs(0, 7'd4, 7'd0);
        #1;
        expect_v("byp_s3_tag", 6);  check(t1(3));
        expect_v("byp_s3_pend", 1); check(32'(src1_pend[3]));
        expect_v("byp_s1_tag", 1);  check(t2(1));
        expect_v("byp_s1_pend", 1); check(32'(src2_pend[1]));
        expect_v("byp_s2_tag", 1);  check(t1(2));
        expect_v("byp_s0_pend", 0); check(32'(src1_pend[0]));
        tick();
        expect_v("byp_e4", 32'h16); check(entry(4));

        // Squash by tag, with the same-cycle enqueue ignored.
        clear_inputs();
        set_wr(0, 7'd8, 4'd5);
        set_wr(1, 7'd9, 4'd10);
        tick();
        expect_v("sq_pre_e8", 32'h15); check(entry(8));
        expect_v("sq_pre_e9", 32'h1A); check(entry(9));
        clear_inputs();
        branchmiss = 1'b1; squash_mask = 16'h0400;
        set_wr(2, 7'd8, 4'd12);
        set_wr(3, 7'd30, 4'd1);
        tick();
        expect_v("sq_e9", 32'h0A);  check(entry(9));
        expect_v("sq_e8", 32'h15);  check(entry(8));
        expect_v("sq_e30", 32'h00); check(entry(30));

        // Squash and commit in one cycle on different registers.
        clear_inputs();
        set_wr(0, 7'd11, 4'd4);
        set_wr(1, 7'd12, 4'd13);
        tick();
        clear_inputs();
        branchmiss = 1'b1; squash_mask = 16'h2000;
        commit0_v = 1'b1; commit0_id = 4'd4; commit0_tgt = 7'd11;
        tick();
        expect_v("mix_e11", 32'h04); check(entry(11));
        expect_v("mix_e12", 32'h0D); check(entry(12));

        // Enqueue beats a matching commit on the same register.
        clear_inputs();
        set_wr(0, 7'd8, 4'd11);
        commit0_v = 1'b1; commit0_id = 4'd5; commit0_tgt = 7'd8;
        tick();
        expect_v("prio_e8", 32'h1B); check(entry(8));

        // r0 is never renamed and never bypassed.
        clear_inputs();
        set_wr(0, 7'd0, 4'd4);
        set_rs(1, 7'd0, 7'd0);
        #1;
        expect_v("r0_tag", 0);  check(t1(1));
        expect_v("r0_pend", 0); check(32'(src1_pend[1]));
        tick();
        expect_v("r0_e0", 0); check(entry(0));

        // Reset mid-operation wipes the table and ignores the enqueue.
        clear_inputs();
        rst = 1'b1;
        set_wr(0, 7'd20, 4'd7);
        tick();
        rst = 1'b0;
        clear_inputs();
        expect_v("mrst_e4", 0);  check(entry(4));
        expect_v("mrst_e20", 0); check(entry(20));
        expect_v("mrst_all", 0); check(32'(|rf_source));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
